// File: rtl/cpu_defs.sv
// Core-wide constants shared by the execute and writeback stages.
package cpu_defs;

  localparam int XLEN = 32;
  localparam int RD_W = 5;

  localparam int FU_ALU  = 0;
  localparam int FU_MEM  = 1;
  localparam int FU_MUL  = 2;
  localparam int FU_DIV  = 3;
  localparam int FU_JUMP = 4;

endpackage

// File: rtl/fu_wb_arbiter_pkg.sv
// Types and helpers local to the FU writeback arbiter.
package fu_wb_arbiter_pkg;

  localparam int N_FU = cpu_defs::FU_JUMP + 1;
  localparam int FU_W = $clog2(N_FU);

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  typedef logic [FU_W-1:0] fu_idx_t;

  // (a + b) mod N_FU for operands already below N_FU; one conditional subtract suffices.
  function automatic fu_idx_t fu_mod_add(input fu_idx_t a, input fu_idx_t b);
    logic [FU_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (FU_W+1)'(N_FU)) begin
      s = s - (FU_W+1)'(N_FU);
    end
    return s[FU_W-1:0];
  endfunction

endpackage

// File: rtl/fu_wb_arbiter_if.sv
// FU result inputs and register-file write port of the writeback arbiter.
interface fu_wb_arbiter_if;
  import cpu_defs::*;
  import fu_wb_arbiter_pkg::*;

  logic [N_FU-1:0]      fu_finish;
  logic [N_FU*XLEN-1:0] fu_res;
  logic [N_FU*RD_W-1:0] fu_rd;
  logic                 wb_ready;
  logic                 wb_en;
  logic [RD_W-1:0]      wb_rd;
  logic [XLEN-1:0]      wb_data;
  logic [FU_W-1:0]      wb_fu;
  logic [N_FU-1:0]      slot_full;
  logic                 overflow;

  modport master (
    output fu_finish, fu_res, fu_rd, wb_ready,
    input  wb_en, wb_rd, wb_data, wb_fu, slot_full, overflow
  );

  modport slave (
    input  fu_finish, fu_res, fu_rd, wb_ready,
    output wb_en, wb_rd, wb_data, wb_fu, slot_full, overflow
  );

endinterface

// File: rtl/wb_slot.sv
// One-entry holding slot for a single functional unit's result.
module wb_slot
  import cpu_defs::*;
  import fu_wb_arbiter_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            capture,
  input  logic            drain,
  input  logic [XLEN-1:0] cap_data,
  input  logic [RD_W-1:0] cap_rd,
  output logic            full,
  output logic [XLEN-1:0] data,
  output logic [RD_W-1:0] rd
);

  slot_state_e     state_q, state_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [RD_W-1:0] rd_q, rd_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
    end
  end

  // A capture on a full slot only lands when the old entry drains that same cycle.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rd_d    = rd_q;
    case (state_q)
      SLOT_EMPTY: begin
        if (capture) begin
          state_d = SLOT_FULL;
          data_d  = cap_data;
          rd_d    = cap_rd;
        end
      end
      SLOT_FULL: begin
        if (drain && capture) begin
          data_d = cap_data;
          rd_d   = cap_rd;
        end else if (drain) begin
          state_d = SLOT_EMPTY;
        end
      end
      default: state_d = SLOT_EMPTY;
    endcase
  end

  always_comb begin
    full = (state_q == SLOT_FULL);
    data = data_q;
    rd   = rd_q;
  end

endmodule

// File: rtl/fu_wb_arbiter.sv
// Writeback arbiter: per-FU holding slots drained one per cycle in round-robin order.
module fu_wb_arbiter
  import cpu_defs::*;
  import fu_wb_arbiter_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  fu_wb_arbiter_if.slave bus
);

  logic [N_FU-1:0] slot_full;
  logic [N_FU-1:0] drain;
  logic [XLEN-1:0] slot_data [N_FU];
  logic [RD_W-1:0] slot_rd   [N_FU];

  fu_idx_t rr_ptr_q, rr_ptr_d;
  logic    overflow_q, overflow_d;
  logic    grant_valid;
  fu_idx_t grant_idx;

  for (genvar g = 0; g < N_FU; g++) begin : g_slot
    wb_slot u_slot (
      .clk      (clk),
      .rst      (rst),
      .capture  (bus.fu_finish[g]),
      .drain    (drain[g]),
      .cap_data (bus.fu_res[g*XLEN +: XLEN]),
      .cap_rd   (bus.fu_rd[g*RD_W +: RD_W]),
      .full     (slot_full[g]),
      .data     (slot_data[g]),
      .rd       (slot_rd[g])
    );
  end

  // First full slot at or after rr_ptr wins; nothing is granted while the RF stalls.
  always_comb begin
    fu_idx_t cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < N_FU; k++) begin
      cand = fu_mod_add(rr_ptr_q, fu_idx_t'(k));
      if (!grant_valid && bus.wb_ready && slot_full[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    drain = '0;
    for (int i = 0; i < N_FU; i++) begin
      drain[i] = grant_valid && (grant_idx == fu_idx_t'(i));
    end
  end

  always_comb begin
    bus.wb_en   = grant_valid;
    bus.wb_rd   = '0;
    bus.wb_data = '0;
    bus.wb_fu   = '0;
    for (int i = 0; i < N_FU; i++) begin
      if (drain[i]) begin
        bus.wb_rd   = slot_rd[i];
        bus.wb_data = slot_data[i];
        bus.wb_fu   = fu_idx_t'(i);
      end
    end
  end

  // A finish into a full slot that is not draining this cycle loses its result.
  always_comb begin
    rr_ptr_d   = grant_valid ? fu_mod_add(grant_idx, fu_idx_t'(1)) : rr_ptr_q;
    overflow_d = overflow_q | (|(bus.fu_finish & slot_full & ~drain));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.slot_full = slot_full;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_fu_wb_arbiter.sv
// Directed scoreboard bench for fu_wb_arbiter: expected writes are queued, a monitor checks them.
module tb_fu_wb_arbiter;

  logic clk;
  logic rst;

  fu_wb_arbiter_if bus ();

  fu_wb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [2:0]  fu;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t expQ[$];
  int   vectors;
  int   miscompares;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic loadLane(input int fu, input logic [4:0] rd, input logic [31:0] data);
    bus.fu_res[fu*32 +: 32] = data;
    bus.fu_rd[fu*5 +: 5]    = rd;
  endtask

  task automatic expectWrite(input logic [2:0] fu, input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    e.fu   = fu;
    e.rd   = rd;
    e.data = data;
    expQ.push_back(e);
  endtask

  // Pulse the finish mask for exactly one edge; returns just after that edge.
  task automatic applyStimulus(input logic [4:0] mask, input logic ready);
    bus.fu_finish = mask;
    bus.wb_ready  = ready;
    step();
    bus.fu_finish = '0;
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n;
    n = 0;
    while ((expQ.size() != 0 || bus.wb_en === 1'b1) && n < budget) begin
      step();
      n++;
    end
    checkOutput(name, 32'(expQ.size()), 32'd0);
  endtask

  // Monitor: every write the DUT presents must match the head of the expected queue.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.wb_en === 1'b1) begin
        if (expQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL wb_unexpected: got fu=%0d rd=%0d data=0x%0h expected no write",
                   bus.wb_fu, bus.wb_rd, bus.wb_data);
        end else begin
          e = expQ.pop_front();
          checkOutput("wb_fu", 32'(bus.wb_fu), 32'(e.fu));
          checkOutput("wb_rd", 32'(bus.wb_rd), 32'(e.rd));
          checkOutput("wb_data", bus.wb_data, e.data);
        end
      end else begin
        checkOutput("idle_zero", bus.wb_data | 32'(bus.wb_rd) | 32'(bus.wb_fu), 32'd0);
      end
    end
  end

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b1;
    bus.fu_finish = 5'b11111;
    bus.fu_res    = {5{32'hDEAD_BEEF}};
    bus.fu_rd     = {5{5'd31}};
    bus.wb_ready  = 1'b1;

    // Reset held two cycles while every FU pulses.
    repeat (2) step();
    checkOutput("rst_wb_en", 32'(bus.wb_en), 32'd0);
    checkOutput("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
    checkOutput("rst_wb_data", bus.wb_data, 32'd0);
    checkOutput("rst_wb_fu", 32'(bus.wb_fu), 32'd0);
    checkOutput("rst_slot_full", 32'(bus.slot_full), 32'd0);
    checkOutput("rst_overflow", 32'(bus.overflow), 32'd0);
    rst           = 1'b0;
    bus.fu_finish = '0;
    step();
    checkOutput("post_rst_full", 32'(bus.slot_full), 32'd0);
    checkOutput("post_rst_en", 32'(bus.wb_en), 32'd0);

    // Single DIV result: written the cycle after its finish edge.
    loadLane(3, 5'd3, 32'h0000_0007);
    expectWrite(3'd3, 5'd3, 32'h0000_0007);
    applyStimulus(5'b01000, 1'b1);
    checkOutput("t2_en", 32'(bus.wb_en), 32'd1);
    checkOutput("t2_rd", 32'(bus.wb_rd), 32'd3);
    checkOutput("t2_data", bus.wb_data, 32'd7);
    checkOutput("t2_fu", 32'(bus.wb_fu), 32'd3);
    checkOutput("t2_full", 32'(bus.slot_full), 32'b01000);
    step();
    checkOutput("t2_en_after", 32'(bus.wb_en), 32'd0);
    checkOutput("t2_full_after", 32'(bus.slot_full), 32'd0);
    waitDrain("t2_drain", 10);

    // rr_ptr is 4: slots 1 and 4 together grant 4 then 1, leaving rr_ptr at 2.
    loadLane(1, 5'd11, 32'h1111_0001);
    loadLane(4, 5'd14, 32'h4444_0004);
    expectWrite(3'd4, 5'd14, 32'h4444_0004);
    expectWrite(3'd1, 5'd11, 32'h1111_0001);
    applyStimulus(5'b10010, 1'b1);
    waitDrain("t4_drain", 10);

    // From rr_ptr 2, slots 1 and 3 grant 3 before 1.
    loadLane(1, 5'd21, 32'h2222_0001);
    loadLane(3, 5'd23, 32'h2222_0003);
    expectWrite(3'd3, 5'd23, 32'h2222_0003);
    expectWrite(3'd1, 5'd21, 32'h2222_0001);
    applyStimulus(5'b01010, 1'b1);
    waitDrain("t4b_drain", 10);

    // Grant of slot 4 wraps rr_ptr to 0.
    loadLane(4, 5'd4, 32'h0000_0044);
    expectWrite(3'd4, 5'd4, 32'h0000_0044);
    applyStimulus(5'b10000, 1'b1);
    waitDrain("wrap_drain", 10);

    // All five at once from rr_ptr 0: five back-to-back writes in index order; rd=0 included.
    for (int i = 0; i < 5; i++) begin
      loadLane(i, 5'(i == 0 ? 0 : 8 + i), 32'hA000_0000 + 32'(i));
      expectWrite(3'(i), 5'(i == 0 ? 0 : 8 + i), 32'hA000_0000 + 32'(i));
    end
    applyStimulus(5'b11111, 1'b1);
    for (int c = 0; c < 5; c++) begin
      checkOutput("t3_en", 32'(bus.wb_en), 32'd1);
      checkOutput("t3_fu", 32'(bus.wb_fu), 32'(c));
      step();
    end
    checkOutput("t3_en_end", 32'(bus.wb_en), 32'd0);
    waitDrain("t3_drain", 10);

    // rr_ptr back at 0: slots 0 and 2 grant 0 first.
    loadLane(0, 5'd1, 32'h0000_0C00);
    loadLane(2, 5'd2, 32'h0000_0C02);
    expectWrite(3'd0, 5'd1, 32'h0000_0C00);
    expectWrite(3'd2, 5'd2, 32'h0000_0C02);
    applyStimulus(5'b00101, 1'b1);
    waitDrain("t3b_drain", 10);

    // Drain and refill slot 0 in the same cycle: both values written, nothing lost.
    loadLane(0, 5'd1, 32'd5);
    expectWrite(3'd0, 5'd1, 32'd5);
    expectWrite(3'd0, 5'd2, 32'd9);
    bus.fu_finish = 5'b00001;
    bus.wb_ready  = 1'b1;
    step();
    loadLane(0, 5'd2, 32'd9);
    checkOutput("t6_old_data", bus.wb_data, 32'd5);
    checkOutput("t6_full_pre", 32'(bus.slot_full), 32'b00001);
    step();
    bus.fu_finish = '0;
    checkOutput("t6_full_kept", 32'(bus.slot_full), 32'b00001);
    checkOutput("t6_en", 32'(bus.wb_en), 32'd1);
    checkOutput("t6_new_data", bus.wb_data, 32'd9);
    waitDrain("t6_drain", 10);
    checkOutput("t6_overflow", 32'(bus.overflow), 32'd0);

    // Backpressure on MUL: second finish is dropped, old data written later.
    loadLane(2, 5'd10, 32'h0000_AAAA);
    expectWrite(3'd2, 5'd10, 32'h0000_AAAA);
    applyStimulus(5'b00100, 1'b0);
    for (int c = 0; c < 3; c++) begin
      checkOutput("t5_stall_en", 32'(bus.wb_en), 32'd0);
      checkOutput("t5_stall_full", 32'(bus.slot_full), 32'b00100);
      step();
    end
    checkOutput("t5_no_overflow_yet", 32'(bus.overflow), 32'd0);
    loadLane(2, 5'd11, 32'h0000_BBBB);
    applyStimulus(5'b00100, 1'b0);
    checkOutput("t5_overflow", 32'(bus.overflow), 32'd1);
    checkOutput("t5_full", 32'(bus.slot_full), 32'b00100);
    bus.wb_ready = 1'b1;
    waitDrain("t5_drain", 10);
    checkOutput("t5_overflow_sticky", 32'(bus.overflow), 32'd1);

    // Reset mid-operation discards held results and clears overflow.
    loadLane(1, 5'd7, 32'h0000_7777);
    applyStimulus(5'b00010, 1'b0);
    checkOutput("midrst_full_pre", 32'(bus.slot_full), 32'b00010);
    rst = 1'b1;
    step();
    rst          = 1'b0;
    bus.wb_ready = 1'b1;
    checkOutput("midrst_full", 32'(bus.slot_full), 32'd0);
    checkOutput("midrst_overflow", 32'(bus.overflow), 32'd0);
    step();
    checkOutput("midrst_en", 32'(bus.wb_en), 32'd0);
    repeat (2) step();
    checkOutput("final_queue", 32'(expQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
